// File: rtl/addsub_arbiter_if.sv
// Handshake bundle for addsub_arbiter: two requesters, the external add/sub
// datapath and the response channel. slave = arbiter side, master = environment.
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [14:0] req0_a;
    logic [14:0] req0_b;
    logic        req0_sub;

    logic        req1_valid;
    logic        req1_ready;
    logic [14:0] req1_a;
    logic [14:0] req1_b;
    logic        req1_sub;

    logic [14:0] dp_a;
    logic [14:0] dp_b;
    logic        dp_c0;
    logic [14:0] dp_s;
    logic        dp_c;
    logic        dp_v;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [14:0] rsp_s;
    logic        rsp_c;
    logic        rsp_v;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output dp_a, dp_b, dp_c0,
        input  dp_s, dp_c, dp_v,
        output rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  dp_a, dp_b, dp_c0,
        output dp_s, dp_c, dp_v,
        input  rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v, busy,
        output rsp_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of an external 15-bit add/sub datapath.
// Optional macro ADDSUB_ARB_SAT_EN saturates the captured sum on overflow.
module addsub_arbiter #(
    parameter int SETTLE_CYC = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    addsub_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(SETTLE_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_busy;
    logic        r_prio;
    logic [1:0]  r_cnt;
    logic        r_gnt_id;

    logic [14:0] r_dp_a;
    logic [14:0] r_dp_b;
    logic        r_dp_c0;

    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [14:0] r_rsp_s;
    logic        r_rsp_c;
    logic        r_rsp_v;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_capture;
    logic [14:0] w_cap_s;

`ifdef ADDSUB_ARB_SAT_EN
    function automatic logic [14:0] sat_sum(input logic [14:0] s, input logic v);
        logic [14:0] res;
        if (v) begin
            res = s[14] ? 15'h3FFF : 15'h4000;
        end else begin
            res = s;
        end
        return res;
    endfunction
`endif

    // Grant logic: only in IDLE and never while reset is held; PRIO breaks ties.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!i_rst && (r_state == ST_IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign w_accept = w_grant0 | w_grant1;

    // Next-state decode; capture happens on the SETTLE edge where the counter is spent.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Captured sum, saturated on overflow when the feature is built in.
    always_comb begin
`ifdef ADDSUB_ARB_SAT_EN
        w_cap_s = sat_sum(bus.dp_s, bus.dp_v);
`else
        w_cap_s = bus.dp_s;
`endif
    end

    // State register with BUSY tracked alongside it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Priority, settle counter and grant index; the index reaches RSP_ID only at
    // capture so a consumed response keeps its ID.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio   <= 1'b0;
            r_cnt    <= 2'd0;
            r_gnt_id <= 1'b0;
        end else if (w_accept) begin
            r_prio   <= w_grant0;
            r_cnt    <= CNT_LOAD;
            r_gnt_id <= w_grant1;
        end else if ((r_state == ST_SETTLE) && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    // Operand registers driving the external datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dp_a  <= 15'd0;
            r_dp_b  <= 15'd0;
            r_dp_c0 <= 1'b0;
        end else if (w_accept) begin
            r_dp_a  <= w_grant1 ? bus.req1_a   : bus.req0_a;
            r_dp_b  <= w_grant1 ? bus.req1_b   : bus.req0_b;
            r_dp_c0 <= w_grant1 ? bus.req1_sub : bus.req0_sub;
        end
    end

    // Response registers: loaded on capture, held until and after consumption.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_s     <= 15'd0;
            r_rsp_c     <= 1'b0;
            r_rsp_v     <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt_id;
            r_rsp_s     <= w_cap_s;
            r_rsp_c     <= bus.dp_c;
            r_rsp_v     <= bus.dp_v;
        end else if ((r_state == ST_RESP) && r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.dp_a       = r_dp_a;
    assign bus.dp_b       = r_dp_b;
    assign bus.dp_c0      = r_dp_c0;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_s      = r_rsp_s;
    assign bus.rsp_c      = r_rsp_c;
    assign bus.rsp_v      = r_rsp_v;
    assign bus.busy       = r_busy;

endmodule
